// File: rtl/shift_register_with_valid_ready_if.sv
// rtl/shift_register_with_valid_ready_if.sv - valid/ready handshake bundle for the elastic shift pipeline
interface shift_register_with_valid_ready_if #(
  parameter int width = 8,
  parameter int depth = 8
);
  localparam int cw = $clog2(depth + 1);

  logic             in_vld;
  logic [width-1:0] in_data;
  logic             in_rdy;
  logic             out_vld;
  logic [width-1:0] out_data;
  logic             out_rdy;
  logic [cw-1:0]    count;

  modport master (
    output in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_data, count
  );

  modport slave (
    input  in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_data, count
  );
endinterface

// File: rtl/shift_register_with_valid_ready.sv
// rtl/shift_register_with_valid_ready.sv - depth-stage elastic shift pipeline with bubble collapse
module shift_register_with_valid_ready #(
  parameter int width = 8,
  parameter int depth = 8
) (
  input logic                          clk,
  input logic                          rst,
  shift_register_with_valid_ready_if.slave bus
);
  localparam int cw = $clog2(depth + 1);
  localparam logic [cw-1:0] cnt_one = cw'(1);

  logic [depth-1:0] vld;
  logic [width-1:0] data [depth];
  logic [depth-1:0] acc;
  logic [cw-1:0]    count_q;
  logic             in_xfer;
  logic             out_xfer;

  // acc[i] is the unrolled ripple: a stage may advance if any stage at or
  // below it toward the output is empty, or the consumer is taking data.
  always_comb begin
    logic full_below;
    acc = '0;
    for (int i = 0; i < depth; i++) begin
      full_below = 1'b1;
      for (int j = i; j < depth; j++) full_below = full_below & vld[j];
      acc[i] = !full_below | bus.out_rdy;
    end
  end

  assign in_xfer      = bus.in_vld & acc[0];
  assign out_xfer     = vld[depth-1] & bus.out_rdy;
  assign bus.in_rdy   = acc[0];
  assign bus.out_vld  = vld[depth-1];
  assign bus.out_data = data[depth-1];
  assign bus.count    = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld     <= '0;
      count_q <= '0;
      for (int i = 0; i < depth; i++) data[i] <= '0;
    end else begin
      if (acc[0]) begin
        vld[0]  <= bus.in_vld;
        data[0] <= bus.in_data;
      end
      for (int i = 1; i < depth; i++) begin
        if (acc[i]) begin
          vld[i]  <= vld[i-1];
          data[i] <= data[i-1];
        end
      end
      case ({in_xfer, out_xfer})
        2'b10:   count_q <= count_q + cnt_one;
        2'b01:   count_q <= count_q - cnt_one;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_register_with_valid_ready.sv
// tb/tb_shift_register_with_valid_ready.sv - scoreboard bench for the elastic shift pipeline
module tb_shift_register_with_valid_ready;
  localparam int width = 8;
  localparam int depth = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shift_register_with_valid_ready_if #(.width(width), .depth(depth)) bus ();

  shift_register_with_valid_ready #(.width(width), .depth(depth)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [width-1:0] exp_q[$];
  logic             prev_stall = 1'b0;
  logic [width-1:0] prev_data  = '0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
  endtask

  // Monitor: inputs settle at posedge+1, so at negedge the values are exactly
  // what the next rising edge will see.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check(bus.count == exp_q.size(), "count_vs_model", bus.count, exp_q.size());
      check(bus.in_rdy == ((exp_q.size() < depth) || bus.out_rdy), "in_rdy_vs_model",
            bus.in_rdy, (exp_q.size() < depth) || bus.out_rdy);
      if (prev_stall)
        check(bus.out_vld && bus.out_data == prev_data, "stall_stable", bus.out_data, prev_data);
      if (bus.out_vld && bus.out_rdy) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "pop_empty", bus.out_data, 0);
        end else begin
          logic [width-1:0] e;
          e = exp_q.pop_front();
          check(bus.out_data == e, "out_data_order", bus.out_data, e);
        end
      end
      if (bus.in_vld && bus.in_rdy) exp_q.push_back(bus.in_data);
      prev_stall = bus.out_vld && !bus.out_rdy;
      prev_data  = bus.out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    k = 0;
    while (bus.count != 0 && k < 20) begin
      tick();
      k++;
    end
    tick();
    check(bus.count == 0 && !bus.out_vld, "drain_empty", bus.count, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    bit took;
    bus.in_vld  = 1'b0;
    bus.in_data = '0;
    bus.out_rdy = 1'b0;
    #23;
    check(!bus.out_vld, "reset_out_vld", bus.out_vld, 0);
    check(bus.out_data == 0, "reset_out_data", bus.out_data, 0);
    check(bus.count == 0, "reset_count", bus.count, 0);
    check(bus.in_rdy, "reset_in_rdy", bus.in_rdy, 1);
    rst = 1'b0;
    tick();

    // Latency and full throughput
    bus.out_rdy = 1'b1;
    bus.in_vld  = 1'b1;
    bus.in_data = 8'h11; tick();
    bus.in_data = 8'h22; tick();
    bus.in_data = 8'h33; tick();
    bus.in_vld  = 1'b0;
    check(bus.count == 3, "lat_count_peak", bus.count, 3);
    check(!bus.out_vld, "lat_not_yet", bus.out_vld, 0);
    tick();
    check(bus.out_vld && bus.out_data == 8'h11, "lat_first", bus.out_data, 8'h11);
    tick();
    check(bus.out_vld && bus.out_data == 8'h22, "lat_second", bus.out_data, 8'h22);
    tick();
    check(bus.out_vld && bus.out_data == 8'h33, "lat_third", bus.out_data, 8'h33);
    tick();
    check(!bus.out_vld && bus.count == 0, "lat_end", bus.count, 0);

    // Fill under stall
    bus.out_rdy = 1'b0;
    bus.in_vld  = 1'b1;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      bus.in_data = 8'hA0 + 8'(idx);
      took = bus.in_rdy;
      tick();
      if (took) idx++;
    end
    check(idx == 4, "fill_accepts", idx, 4);
    check(!bus.in_rdy, "fill_in_rdy_low", bus.in_rdy, 0);
    check(bus.count == 4, "fill_count", bus.count, 4);
    check(bus.out_vld && bus.out_data == 8'hA0, "fill_head", bus.out_data, 8'hA0);
    bus.out_rdy = 1'b1;
    #1;
    check(bus.in_rdy, "fill_release_in_rdy", bus.in_rdy, 1);
    while (idx < 6) begin
      bus.in_data = 8'hA0 + 8'(idx);
      took = bus.in_rdy;
      tick();
      if (took) idx++;
    end
    drain();

    // Bubble collapse
    bus.out_rdy = 1'b0;
    bus.in_vld  = 1'b1; bus.in_data = 8'h01; tick();
    bus.in_vld  = 1'b0; tick(); tick();
    bus.in_vld  = 1'b1; bus.in_data = 8'h02; tick();
    bus.in_vld  = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check(bus.count == 2, "bubble_count", bus.count, 2);
    check(bus.in_rdy, "bubble_in_rdy", bus.in_rdy, 1);
    check(bus.out_vld && bus.out_data == 8'h01, "bubble_head", bus.out_data, 8'h01);
    bus.out_rdy = 1'b1;
    tick();
    check(bus.out_vld && bus.out_data == 8'h02, "bubble_packed", bus.out_data, 8'h02);
    drain();

    // Simultaneous transfer at full
    bus.out_rdy = 1'b0;
    bus.in_vld  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.in_data = 8'h10 + 8'(c);
      tick();
    end
    check(bus.count == 4 && !bus.in_rdy, "full_stalled", bus.count, 4);
    bus.out_rdy = 1'b1;
    bus.in_data = 8'h14;
    #1;
    check(bus.in_rdy, "full_drain_in_rdy", bus.in_rdy, 1);
    tick();
    bus.in_vld = 1'b0;
    check(bus.count == 4, "simul_count", bus.count, 4);
    check(bus.out_data == 8'h11, "simul_next_head", bus.out_data, 8'h11);
    drain();

    // Random backpressure
    for (int c = 0; c < 200; c++) begin
      bus.in_vld  = ($urandom_range(0, 99) < 60);
      bus.out_rdy = ($urandom_range(0, 99) < 50);
      bus.in_data = 8'($urandom_range(0, 255));
      tick();
    end
    drain();

    // Reset mid-operation
    bus.out_rdy = 1'b0;
    bus.in_vld  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.in_data = 8'h30 + 8'(c);
      tick();
    end
    bus.in_vld = 1'b0;
    check(bus.count == 3, "pre_reset_count", bus.count, 3);
    #1 rst = 1'b1;
    #1;
    check(!bus.out_vld, "async_rst_out_vld", bus.out_vld, 0);
    check(bus.count == 0, "async_rst_count", bus.count, 0);
    check(bus.in_rdy, "async_rst_in_rdy", bus.in_rdy, 1);
    exp_q.delete();
    rst = 1'b0;
    tick();
    bus.out_rdy = 1'b1;
    bus.in_vld  = 1'b1; bus.in_data = 8'h5A; tick();
    bus.in_vld  = 1'b0; tick(); tick();
    check(!bus.out_vld, "post_rst_not_yet", bus.out_vld, 0);
    tick();
    check(bus.out_vld && bus.out_data == 8'h5A, "post_rst_out", bus.out_data, 8'h5A);
    tick();
    check(!bus.out_vld, "post_rst_alone", bus.out_vld, 0);

    check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/shift_register_with_valid_ready.md
Name: shift_register_with_valid_ready

Overview:
- Elastic, `depth`-stage shift pipeline with a valid/ready handshake on both sides.
- It is the consumer-facing complement of the valid-only shift register. A downstream receiver can stall the pipeline with `out_rdy`. Empty stages (bubbles) still collapse, so no transfer is ever lost or duplicated.
- It sits between a valid-only producer stage and a backpressuring consumer, such as a FIFO writer or an arbiter input.

Parameters:
- `width`, 8, data bits per transfer.
- `depth`, 8, number of register stages; legal range ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_vld`  in  1  upstream transfer valid.
- `in_data`  in  `width`  upstream payload.
- `in_rdy`  out  1  pipeline can accept a transfer this cycle.
- `out_vld`  out  1  last stage holds a valid transfer.
- `out_data`  out  `width`  payload of the last stage.
- `out_rdy`  in  1  downstream accepts a transfer this cycle.
- `count`  out  `$clog2(depth+1)`  number of valid stages currently occupied.

Behaviour:
- **Reset state.** Asynchronous reset clears every stage valid bit, all stage data, and `count` to 0.
  - While and after `rst` is high: `out_vld`=0, `out_data`=0, `count`=0, `in_rdy`=1.
- **Stage state.** Each stage i (0..depth-1) holds `vld[i]` and `data[i]`. Stage 0 is the input stage; stage depth-1 drives `out_vld`/`out_data` directly from registers.
- **Accept chain (combinational).**
  - `acc[depth-1] = !vld[depth-1] | out_rdy`
  - `acc[i] = !vld[i] | acc[i+1]`
  - `in_rdy = acc[0]`
  - `in_rdy` therefore has a combinational path from `out_rdy`. This path is permitted and documented; no skid buffer is required.
- **Handshake events.**
  - Input transfer occurs when `in_vld & in_rdy` at a rising edge.
  - Output transfer occurs when `out_vld & out_rdy` at a rising edge.
- **Per-edge update, stage i > 0.**
  - If `acc[i]`: `vld[i] <= vld[i-1]` and `data[i] <= data[i-1]`.
  - Else: hold.
- **Per-edge update, stage 0.**
  - If `acc[0]`: `vld[0] <= in_vld` and `data[0] <= in_data`.
  - Else: hold.
- **Invalid data.** Data of an invalid stage is don't-care, but must not be presented as valid. `data[i]` may update while `vld[i-1]`=0.
- **Bubble collapse.** Bubbles advance independently of `out_rdy`. A stalled output does not stall stages that have an empty stage downstream.
- **Latency.** With the pipe empty and `out_rdy`=1 throughout, a transfer accepted at edge E appears on `out_vld`/`out_data` immediately after edge E+depth-1, i.e. depth register stages. Full throughput is one transfer per cycle.
- **Ordering.** Strict FIFO order; no drops, no duplicates.
- **Count update.** `count <= count + in_xfer - out_xfer`.
  - Simultaneous input and output transfer leaves `count` unchanged.
  - `count` never exceeds depth and never underflows.
- **Full.** `count`=depth with `out_rdy`=0 gives `in_rdy`=0. Further `in_vld` is ignored and the upstream must hold its data.
- **Full and draining.** `count`=depth with `out_rdy`=1 gives `in_rdy`=1; one in and one out per cycle.
- **Empty.** `out_vld`=0; `out_rdy` has no effect.
- **Stalled output.** `out_vld`/`out_data` hold stable while `out_rdy`=0.
- **Reset mid-operation.** All in-flight transfers are discarded immediately (asynchronous). The first edge after `rst` deasserts behaves as empty.

Test Plan (width=8, depth=4):
- **Latency, full throughput.** Reset, `out_rdy`=1, push 0x11,0x22,0x33 on consecutive cycles → `out_vld` after 4th edge with 0x11, then 0x22, 0x33 back-to-back; `count` peaks at 3, ends 0.
- **Fill under stall.** `out_rdy`=0, push 0xA0..0xA5 continuously → `in_rdy` drops after 4 accepts; `count`=4; `out_data`=0xA0 held stable; 0xA4/0xA5 not accepted until `out_rdy`=1.
- **Bubble collapse.** `out_rdy`=0, push 0x01, idle 2 cycles, push 0x02 → both pack into stages 3,2 within 4 edges; `count`=2; `in_rdy` stays 1.
- **Simultaneous transfer at full.** Full with 0x10..0x13, `out_rdy`=1 and push 0x14 same cycle → 0x10 delivered, 0x14 accepted, `count` stays 4, `in_rdy`=1.
- **Random backpressure.** 200 random `in_vld`/`out_rdy` cycles against scoreboard → output sequence equals accepted input sequence; `count` equals the scoreboard delta every cycle.
- **Reset mid-operation.** With `count`=3, assert `rst` asynchronously between edges → `out_vld`=0, `count`=0, `in_rdy`=1 without a clock edge; next push 0x5A is output alone after 4 edges.
